nn_frame_driver: RTL and testbench
==================================

# nn_frame_driver

Initiator for the batch-norm jet-tagging network's parallel frame interface. It deserializes a stream of WIDTH-bit fixed-point features into one INPUT_SIZE-word frame and fires it at the network with a one-cycle `input_ready` strobe. It then waits for `output_ready`, captures the OUTPUT_SIZE class scores, and serializes them onto a valid/ready result stream. It sits between the board-level host link and the network core on the benchmark build, and also serves as the bench's stimulus/capture engine.

## Interface
- WIDTH, 16, bits per feature/score word (signed, NFRAC fractional bits; passed through unchanged)
- NFRAC, 10, fractional bits (documentation only; no arithmetic on data)
- INPUT_SIZE, 16, feature words per frame
- OUTPUT_SIZE, 5, score words per frame
- TIMEOUT, 1023, maximum WAIT cycles before abort
- LAT_W, 16, latency counter width
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- s_valid  in  1  feature word valid
- s_ready  out  1  driver accepts feature word
- s_data  in  WIDTH  feature word, signed
- nn_input_ready  out  1  one-cycle frame strobe to network
- nn_input_data  out  WIDTH x INPUT_SIZE  frame to network; word k = k-th accepted beat
- nn_output_ready  in  1  network result strobe
- nn_output_data  in  WIDTH x OUTPUT_SIZE  network scores
- m_valid  out  1  score word valid
- m_ready  in  1  downstream accepts score word
- m_data  out  WIDTH  score word, signed
- m_last  out  1  marks score word OUTPUT_SIZE-1
- lat_cycles  out  LAT_W  latency of last completed frame
- frame_count  out  32  completed frames (wraps)
- err_timeout  out  1  sticky timeout flag

## Operation
- FSM states: LOAD, FIRE, WAIT, DRAIN; reset state LOAD.
- LOAD: s_ready=1. Each s_valid&&s_ready writes buf[idx], idx++. On beat INPUT_SIZE-1, go to FIRE. Frame boundaries are implied by count only; there is no sideband.
- FIRE (exactly 1 cycle): nn_input_ready=1; latency counter cleared; next state WAIT.
- nn_input_data is driven from buf continuously. It is stable from FIRE until the next frame's first accepted beat.
- WAIT: nn_output_ready is sampled. When it is high, nn_output_data is captured into obuf and the state moves to DRAIN. nn_output_ready is ignored in every other state, including FIRE.
- Timeout: if TIMEOUT WAIT cycles pass without nn_output_ready, obuf is zeroed, err_timeout is set, and the state moves to DRAIN. err_timeout clears only on reset.
- DRAIN: m_valid=1 and m_data=obuf[oidx]. oidx advances on m_valid&&m_ready. m_last=1 when oidx==OUTPUT_SIZE-1. The accept of the last word returns to LOAD and increments frame_count.
- m_data/m_last are held stable while m_valid&&!m_ready.
- s_ready=0 in FIRE, WAIT and DRAIN. Upstream beats are back-pressured, never dropped.

## Timing
- Reset values: s_ready=0 while reset is high, then 1 from the first cycle after release. nn_input_ready=0, nn_input_data all 0, m_valid=0, m_data=0, m_last=0, lat_cycles=0, frame_count=0, err_timeout=0. buf, obuf, idx and oidx are all 0.
- Reset mid-frame discards the partial frame and any pending scores; no strobe is emitted.
- All outputs are registered or decoded from state; there are no combinational paths from in to out.
- lat_cycles = cycles from the FIRE cycle to the WAIT cycle that samples nn_output_ready. If the result arrives in the cycle right after FIRE, lat_cycles=1. The value saturates at 2^LAT_W-1 and updates on capture only; on timeout it is unchanged.
- Best-case frame period with continuous s_valid, m_ready and network latency L: INPUT_SIZE + 1 + L + OUTPUT_SIZE cycles.

## Configuration
- NN_DRIVER_LATENCY_EN defined: the latency counter and lat_cycles register are built as above.
- NN_DRIVER_LATENCY_EN undefined: no counter logic; lat_cycles is tied to 0.
- The timeout still uses its own WAIT counter in both builds.

## Test plan
- Stream features 1..16 (one per cycle) with a network model responding at L=3 with scores 10..14:
  - nn_input_ready pulses once.
  - nn_input_data[k]=k+1.
  - m_data emits 10,11,12,13,14 with m_last on 14.
  - lat_cycles=3 (0 with macro off).
  - frame_count=1.
- Network model never asserts nn_output_ready:
  - After 1023 WAIT cycles, five zero scores are emitted.
  - err_timeout=1 and stays 1 over the next good frame.
- m_ready toggled 1/0 every cycle during DRAIN:
  - Each score is held while stalled.
  - Exactly 5 accepts occur, in order.
- Spurious nn_output_ready during LOAD and FIRE, then real at L=2:
  - Spurious strobes are ignored.
  - lat_cycles=2.
  - Scores are captured from the L=2 strobe.
- Assert reset after 9 feature beats, then send a full frame 100..115:
  - No strobe from the partial frame.
  - nn_input_data[0]=100.
  - frame_count=1.
- s_valid held high during WAIT/DRAIN:
  - s_ready=0 and no words are lost.
  - The next frame starts with the held word.

Source files
------------

// File: rtl/nn_frame_driver.sv
// nn_frame_driver: deserializes WIDTH-bit feature beats into one INPUT_SIZE-word frame,
// strobes it into the network, captures OUTPUT_SIZE scores and serializes them on a
// valid/ready result stream.
// Optional feature macro: NN_DRIVER_LATENCY_EN builds the FIRE-to-result latency counter;
// without it lat_cycles is tied to zero.
module nn_frame_driver #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NFRAC       = 10,
  parameter int unsigned INPUT_SIZE  = 16,
  parameter int unsigned OUTPUT_SIZE = 5,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned LAT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [WIDTH-1:0]               s_data,
  output logic                           nn_input_ready,
  output logic [WIDTH*INPUT_SIZE-1:0]    nn_input_data,
  input  logic                           nn_output_ready,
  input  logic [WIDTH*OUTPUT_SIZE-1:0]   nn_output_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [WIDTH-1:0]               m_data,
  output logic                           m_last,
  output logic [LAT_W-1:0]               lat_cycles,
  output logic [31:0]                    frame_count,
  output logic                           err_timeout
);

  localparam int unsigned IdxW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned OidxW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  // Data words are passed through untouched, so NFRAC only has to describe a legal format.
  if (NFRAC >= WIDTH) begin : g_bad_nfrac
    $error("NFRAC must be smaller than WIDTH");
  end

  typedef enum logic [1:0] {StLoad, StFire, StWait, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [OidxW-1:0]         oidx_q, oidx_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic [WIDTH-1:0]         fbuf_q [INPUT_SIZE];
  logic [WIDTH-1:0]         fbuf_d [INPUT_SIZE];
  logic [WIDTH-1:0]         obuf_q [OUTPUT_SIZE];
  logic [WIDTH-1:0]         obuf_d [OUTPUT_SIZE];
  logic [31:0]              frame_count_q, frame_count_d;
  logic                     err_timeout_q, err_timeout_d;
  logic                     s_ready_q, s_ready_d;

  // Next-state logic for the frame FSM, buffers and counters.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    oidx_d        = oidx_q;
    wait_d        = wait_q;
    fbuf_d        = fbuf_q;
    obuf_d        = obuf_q;
    frame_count_d = frame_count_q;
    err_timeout_d = err_timeout_q;
    unique case (state_q)
      StLoad: begin
        if (s_valid && s_ready_q) begin
          fbuf_d[idx_q] = s_data;
          if (idx_q == IdxW'(INPUT_SIZE - 1)) begin
            idx_d   = '0;
            state_d = StFire;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFire: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (nn_output_ready) begin
          for (int k = 0; k < OUTPUT_SIZE; k++) obuf_d[k] = nn_output_data[k*WIDTH +: WIDTH];
          state_d = StDrain;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          // No result: emit an all-zero score frame so downstream stays in frame sync.
          for (int k = 0; k < OUTPUT_SIZE; k++) obuf_d[k] = '0;
          err_timeout_d = 1'b1;
          state_d       = StDrain;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDrain: begin
        if (m_ready) begin
          if (oidx_q == OidxW'(OUTPUT_SIZE - 1)) begin
            oidx_d        = '0;
            frame_count_d = frame_count_q + 32'd1;
            state_d       = StLoad;
          end else begin
            oidx_d = oidx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
    // Registered so s_ready stays low for as long as reset is held.
    s_ready_d = (state_d == StLoad);
  end

  // State registers; reset drops any partial frame and pending scores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StLoad;
      idx_q         <= '0;
      oidx_q        <= '0;
      wait_q        <= '0;
      fbuf_q        <= '{default: '0};
      obuf_q        <= '{default: '0};
      frame_count_q <= '0;
      err_timeout_q <= 1'b0;
      s_ready_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      oidx_q        <= oidx_d;
      wait_q        <= wait_d;
      fbuf_q        <= fbuf_d;
      obuf_q        <= obuf_d;
      frame_count_q <= frame_count_d;
      err_timeout_q <= err_timeout_d;
      s_ready_q     <= s_ready_d;
    end
  end

`ifdef NN_DRIVER_LATENCY_EN
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0] lat_cycles_q, lat_cycles_d;

  // Count from FIRE (the first WAIT cycle reads 1); latch on capture, hold on timeout.
  always_comb begin
    lat_cnt_d    = lat_cnt_q;
    lat_cycles_d = lat_cycles_q;
    if (state_q == StFire) begin
      lat_cnt_d = LAT_W'(1);
    end else if (state_q == StWait) begin
      if (nn_output_ready) begin
        lat_cycles_d = lat_cnt_q;
      end else if (lat_cnt_q != '1) begin
        lat_cnt_d = lat_cnt_q + 1'b1;
      end
    end
  end

  // Latency registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt_q    <= '0;
      lat_cycles_q <= '0;
    end else begin
      lat_cnt_q    <= lat_cnt_d;
      lat_cycles_q <= lat_cycles_d;
    end
  end

  assign lat_cycles = lat_cycles_q;
`else
  assign lat_cycles = '0;
`endif

  for (genvar k = 0; k < INPUT_SIZE; k++) begin : g_in_data
    assign nn_input_data[k*WIDTH +: WIDTH] = fbuf_q[k];
  end

  assign s_ready        = s_ready_q;
  assign nn_input_ready = (state_q == StFire);
  assign m_valid        = (state_q == StDrain);
  assign m_data         = m_valid ? obuf_q[oidx_q] : '0;
  assign m_last         = m_valid && (oidx_q == OidxW'(OUTPUT_SIZE - 1));
  assign frame_count    = frame_count_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_nn_frame_driver.sv
// Self-checking bench for nn_frame_driver: table-driven frame scenarios, hand-written
// timeout / reset / back-pressure sequences and randomized frames against a frame-level
// reference model (consecutive 16-word chunks in, 5 scores or zeros out).
module tb_nn_frame_driver;

  localparam int unsigned W   = 16;
  localparam int unsigned IN  = 16;
  localparam int unsigned OUT = 5;
  localparam int unsigned TO  = 1023;
  localparam int unsigned LW  = 16;
`ifdef NN_DRIVER_LATENCY_EN
  localparam bit LatEn = 1'b1;
`else
  localparam bit LatEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid;
  logic              s_ready;
  logic [W-1:0]      s_data;
  logic              nn_input_ready;
  logic [W*IN-1:0]   nn_input_data;
  logic              nn_output_ready;
  logic [W*OUT-1:0]  nn_output_data;
  logic              m_valid;
  logic              m_ready;
  logic [W-1:0]      m_data;
  logic              m_last;
  logic [LW-1:0]     lat_cycles;
  logic [31:0]       frame_count;
  logic              err_timeout;

  nn_frame_driver #(
    .WIDTH(W), .NFRAC(10), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .TIMEOUT(TO), .LAT_W(LW)
  ) u_dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .nn_input_ready(nn_input_ready), .nn_input_data(nn_input_data),
    .nn_output_ready(nn_output_ready), .nn_output_data(nn_output_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .lat_cycles(lat_cycles), .frame_count(frame_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] feed_q[$];
  logic [W-1:0] exp_stream[$];
  logic [W-1:0] out_q[$];
  logic         last_q[$];
  int           strobes = 0;
  int           cyc = 0;
  logic [W*IN-1:0] fire_snap;

  int           net_lat = 0;
  int           net_cnt = 0;
  logic [W-1:0] net_scores [OUT];
  bit           spur_en = 1'b0;
  int           mr_mode = 0;
  int           sv_mode = 0;

  int           model_frames = 0;
  bit           model_err = 1'b0;
  int           model_lat = 0;

  typedef struct {
    string name;
    int    lat;
    int    mmode;
    int    vmode;
    bit    spur;
    int    feat_base;
    int    score_base;
    int    exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [W*IN-1:0] act,
                            input logic [W*IN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n, input int base);
    logic [W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = (base >= 0) ? W'(base + i) : W'($urandom);
      feed_q.push_back(w);
      exp_stream.push_back(w);
    end
  endtask

  task automatic drive();
    s_valid = (feed_q.size() > 0) && (sv_mode == 0 || $urandom_range(0, 1) == 1);
    s_data  = (feed_q.size() > 0) ? feed_q[0] : W'($urandom);
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = !m_ready;
      default: m_ready = ($urandom_range(0, 1) == 1);
    endcase
  endtask

  // One clock: log handshakes seen this cycle, step the edge, then update the network model.
  task automatic cycle();
    bit           stall;
    logic [W-1:0] pmd;
    logic         pml;
    logic [W*OUT-1:0] pk;
    stall = m_valid && !m_ready;
    pmd   = m_data;
    pml   = m_last;
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      last_q.push_back(m_last);
    end
    if (s_valid && s_ready) void'(feed_q.pop_front());
    if (nn_input_ready) begin
      strobes++;
      fire_snap = nn_input_data;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stall) check("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, pml, pmd}));
    nn_output_ready = 1'b0;
    nn_output_data  = (W*OUT)'({$urandom(), $urandom(), $urandom()});
    if (nn_input_ready) begin
      net_cnt = net_lat;
    end else if (net_cnt > 0) begin
      net_cnt--;
      if (net_cnt == 0) begin
        for (int k = 0; k < OUT; k++) pk[k*W +: W] = net_scores[k];
        nn_output_ready = 1'b1;
        nn_output_data  = pk;
      end
    end
    // Garbage strobes while loading or firing must not be captured.
    if (spur_en && (s_ready || nn_input_ready)) nn_output_ready = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_in_ready"}, 64'(nn_input_ready), 64'(0));
    check_wide({tag, "_in_data"}, nn_input_data, '0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_m_data"}, 64'(m_data), 64'(0));
    check({tag, "_m_last"}, 64'(m_last), 64'(0));
    check({tag, "_lat"}, 64'(lat_cycles), 64'(0));
    check({tag, "_frames"}, 64'(frame_count), 64'(0));
    check({tag, "_err"}, 64'(err_timeout), 64'(0));
  endtask

  // Run one frame through the DUT and compare against the frame-level model.
  task automatic run_frame(input string tag, input int lat, input int mmode, input int vmode,
                           input bit spur, input int score_base, input int exp_lat,
                           input bit exp_to);
    logic [W*IN-1:0] exp_pk;
    logic [W-1:0]    exp_sc;
    int start_out, start_str, fire_cyc, mv_cyc, busy;
    bit done;
    net_lat = lat;
    mr_mode = mmode;
    sv_mode = vmode;
    spur_en = spur;
    for (int k = 0; k < OUT; k++)
      net_scores[k] = (score_base >= 0) ? W'(score_base + k) : W'($urandom);
    for (int k = 0; k < IN; k++) exp_pk[k*W +: W] = exp_stream.pop_front();
    start_out = out_q.size();
    start_str = strobes;
    fire_cyc  = -1;
    mv_cyc    = -1;
    busy      = 0;
    done      = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      drive();
      cycle();
      if (nn_input_ready && fire_cyc < 0) fire_cyc = cyc;
      if (m_valid && fire_cyc >= 0 && mv_cyc < 0) mv_cyc = cyc;
      if (out_q.size() >= start_out + OUT) begin
        done = 1'b1;
        break;
      end
      if (fire_cyc >= 0 && s_ready) busy++;
    end
    spur_en = 1'b0;
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_strobes"}, 64'(strobes - start_str), 64'(1));
    check_wide({tag, "_frame"}, fire_snap, exp_pk);
    check({tag, "_fire_to_drain"}, 64'(mv_cyc - fire_cyc), exp_to ? 64'(TO + 1) : 64'(lat + 1));
    check({tag, "_busy_s_ready"}, 64'(busy), 64'(0));
    if (done) begin
      for (int k = 0; k < OUT; k++) begin
        exp_sc = exp_to ? '0 : net_scores[k];
        check($sformatf("%s_score%0d", tag, k), 64'(out_q[start_out + k]), 64'(exp_sc));
        check($sformatf("%s_last%0d", tag, k), 64'(last_q[start_out + k]), 64'(k == OUT - 1));
      end
    end
    model_frames++;
    if (exp_to) model_err = 1'b1;
    else        model_lat = LatEn ? exp_lat : 0;
    check({tag, "_frame_count"}, 64'(frame_count), 64'(model_frames));
    check({tag, "_err"}, 64'(err_timeout), 64'(model_err));
    check({tag, "_lat"}, 64'(lat_cycles), 64'(model_lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int lat;
    vecs[0] = '{"basic",    3, 0, 0, 1'b0, 1,  10, 3};
    vecs[1] = '{"toggle",   3, 1, 0, 1'b0, -1, -1, 3};
    vecs[2] = '{"spurious", 2, 0, 0, 1'b1, -1, -1, 2};
    vecs[3] = '{"lat1",     1, 2, 1, 1'b0, -1, -1, 1};
    vecs[4] = '{"lat7",     7, 2, 1, 1'b1, -1, -1, 7};

    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    nn_output_ready = 1'b0;
    nn_output_data = '0;

    repeat (3) cycle();
    check_reset_vals("por");
    reset = 1'b0;
    cycle();
    check("por_release_s_ready", 64'(s_ready), 64'(1));

    for (int v = 0; v < 5; v++) begin
      push_words(IN, vecs[v].feat_base);
      run_frame(vecs[v].name, vecs[v].lat, vecs[v].mmode, vecs[v].vmode, vecs[v].spur,
                vecs[v].score_base, vecs[v].exp_lat, 1'b0);
    end

    // Network never answers; the following good frame must keep err_timeout set.
    push_words(IN, -1);
    run_frame("timeout", 0, 0, 0, 1'b0, -1, 0, 1'b1);
    push_words(IN, -1);
    run_frame("after_to", 4, 0, 0, 1'b0, -1, 4, 1'b0);

    // Valid held high through WAIT/DRAIN with the next frame's first word waiting.
    push_words(IN + 1, 500);
    run_frame("hold_a", 2, 1, 0, 1'b0, -1, 2, 1'b0);
    check("hold_word_pending", 64'(feed_q.size()), 64'(1));
    check("hold_valid_high", 64'(s_valid), 64'(1));
    push_words(IN - 1, 600);
    run_frame("hold_b", 3, 0, 0, 1'b0, -1, 3, 1'b0);

    // Reset after 9 beats of a frame.
    push_words(9, 50);
    mr_mode = 0;
    sv_mode = 0;
    net_lat = 3;
    for (int i = 0; i < 100; i++) begin
      drive();
      cycle();
      if (feed_q.size() == 0) break;
    end
    check("partial_accepted", 64'(feed_q.size()), 64'(0));
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    feed_q.delete();
    exp_stream.delete();
    strobes = 0;
    net_cnt = 0;
    model_frames = 0;
    model_err = 1'b0;
    model_lat = 0;
    repeat (2) cycle();
    check("midrst_held_s_ready", 64'(s_ready), 64'(0));
    reset = 1'b0;
    cycle();
    check("midrst_release_s_ready", 64'(s_ready), 64'(1));
    check("midrst_no_strobe", 64'(strobes), 64'(0));
    push_words(IN, 100);
    run_frame("rst_frame", 3, 0, 0, 1'b0, -1, 3, 1'b0);
    check("rst_frame_word0", 64'(nn_input_data[W-1:0]), 64'(100));
    check("rst_total_strobes", 64'(strobes), 64'(1));

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      lat = $urandom_range(1, 20);
      push_words(IN, -1);
      run_frame($sformatf("rand%0d", r), lat, $urandom_range(0, 2), $urandom_range(0, 1),
                $urandom_range(0, 1) == 1, -1, lat, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
